// File: rtl/comp_pkg.sv
// Shared types and result encodings for the sequential wide comparator.
package comp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } comp_state_t;

    // Result encodings, in {g,e,l} order.
    localparam logic [2:0] RES_GT = 3'b100;
    localparam logic [2:0] RES_EQ = 3'b010;
    localparam logic [2:0] RES_LT = 3'b001;

endpackage

// File: rtl/comp2w.sv
// Purely combinational 2-bit unsigned magnitude comparator slice.
module comp2w (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       g,
    output logic       e,
    output logic       l
);

    assign g = (a > b);
    assign e = (a == b);
    assign l = (a < b);

endmodule

// File: rtl/comp_seq.sv
// Sequential WIDTH-bit magnitude comparator: walks one comp2w slice over the
// operand pairs MSB first and stops at the first unequal pair.
module comp_seq
    import comp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             g,
    output logic             e,
    output logic             l
);

    localparam int NP = WIDTH / 2;
    localparam int CW = (NP > 1) ? $clog2(NP) : 1;

    if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
        $fatal(1, "comp_seq: WIDTH must be even and >= 2");
    end

    comp_state_t      state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       res_q, res_d;

    logic slice_g, slice_e, slice_l;

    comp2w u_slice (
        .a (sa_q[WIDTH-1 -: 2]),
        .b (sb_q[WIDTH-1 -: 2]),
        .g (slice_g),
        .e (slice_e),
        .l (slice_l)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        res_d   = res_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    cnt_d   = CW'(NP - 1);
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (slice_g || slice_l) begin
                    res_d   = {slice_g, slice_e, slice_l};
                    state_d = DONE;
                end else if (cnt_q != '0) begin
                    // Pair is equal: bring the next lower pair up to the slice.
                    sa_d  = sa_q << 2;
                    sb_d  = sb_q << 2;
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    res_d   = RES_EQ;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: datapath registers are cleared too, so a reset mid-compare leaves no stale operands.
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign {g, e, l}   = res_q;

endmodule

// File: tb/tb_comp_seq.sv
// Self-checking bench for comp_seq (WIDTH=8): directed scenarios plus a
// randomized cross-check against an arithmetic reference model.
module tb_comp_seq;

    localparam int W  = 8;
    localparam int NP = W / 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, g, e, l;

    int n_cmp = 0;
    int n_bad = 0;

    comp_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .g     (g),
        .e     (e),
        .l     (l)
    );

    always #5 clk = ~clk;

    // Advance one cycle; observation happens 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: result from plain magnitude compare, latency from the index
    // of the first differing 2-bit group counted from the MSB.
    function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                  output logic [2:0] res, output int lat);
        int k;
        k = NP;
        for (int i = 1; i <= NP; i++) begin
            int pa, pb;
            pa = (int'(av) >> (W - 2 * i)) & 3;
            pb = (int'(bv) >> (W - 2 * i)) & 3;
            if (pa != pb) begin
                k = i;
                break;
            end
        end
        res = (av > bv) ? 3'b100 : ((av == bv) ? 3'b010 : 3'b001);
        lat = k + 1;
    endfunction

    // Present a start pulse; returns in cycle 1.
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
        start = 1'b1;
        a     = av;
        b     = bv;
        tick();
        start = 1'b0;
    endtask

    // From cycle 1, wait (bounded) for done; returns in the DONE cycle.
    task automatic wait_done(output int lat, output int busy_n,
                             output logic [2:0] res, output bit timeout);
        lat     = 0;
        busy_n  = 0;
        res     = 3'bxxx;
        timeout = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) begin
                lat     = c;
                res     = {g, e, l};
                timeout = 1'b0;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({busy, done, g, e, l} !== 5'b00000) begin
            n_bad++;
            $display("FAIL reset_state: got %b want 00000", {busy, done, g, e, l});
        end
        tick();
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_idle: busy/done got %b want 00", {busy, done});
        end
    endtask

    task automatic test_directed(input string name, input logic [W-1:0] av,
                                 input logic [W-1:0] bv, input int want_lat,
                                 input logic [2:0] want_res);
        int lat, busy_n;
        logic [2:0] res;
        bit to;
        launch(av, bv);
        wait_done(lat, busy_n, res, to);
        n_cmp++;
        if (to) begin
            n_bad++;
            $display("FAIL %s_timeout: no done within 20 cycles", name);
        end
        n_cmp++;
        if (lat !== want_lat) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d want %0d", name, lat, want_lat);
        end
        n_cmp++;
        if (busy_n !== want_lat - 1) begin
            n_bad++;
            $display("FAIL %s_busy_cycles: got %0d want %0d", name, busy_n, want_lat - 1);
        end
        n_cmp++;
        if (res !== want_res) begin
            n_bad++;
            $display("FAIL %s_result: got %b want %b", name, res, want_res);
        end
        tick();
    endtask

    task automatic test_ignore_hold();
        int first, pulses;
        launch(8'h00, 8'h03);
        tick();
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h00;
        tick();
        start = 1'b0;
        a     = 8'h55;
        b     = 8'hAA;
        first  = 0;
        pulses = 0;
        for (int c = 3; c <= 15; c++) begin
            if (done === 1'b1) begin
                pulses++;
                if (first == 0) first = c;
            end
            if (first != 0) begin
                n_cmp++;
                if ({g, e, l} !== 3'b001) begin
                    n_bad++;
                    $display("FAIL ignore_hold_result c%0d: got %b want 001", c, {g, e, l});
                end
            end
            tick();
        end
        n_cmp++;
        if (first !== 5) begin
            n_bad++;
            $display("FAIL ignore_done_cycle: got %0d want 5", first);
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_bad++;
            $display("FAIL ignore_done_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_back_to_back_reset();
        int lat, busy_n, dones;
        logic [2:0] res;
        bit to;
        launch(8'hC0, 8'h40);
        wait_done(lat, busy_n, res, to);
        start = 1'b1;
        a     = 8'h02;
        b     = 8'h01;
        tick();
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_busy_rise: got %b want 1", busy);
        end
        wait_done(lat, busy_n, res, to);
        n_cmp++;
        if (to || lat !== 5) begin
            n_bad++;
            $display("FAIL b2b_latency: got %0d (timeout %0b) want 5", lat, to);
        end
        n_cmp++;
        if (res !== 3'b100) begin
            n_bad++;
            $display("FAIL b2b_result: got %b want 100", res);
        end
        launch(8'h80, 8'h80);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({busy, done, g, e, l} !== 5'b00000) begin
            n_bad++;
            $display("FAIL midrun_reset: got %b want 00000", {busy, done, g, e, l});
        end
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            if (done === 1'b1 || busy === 1'b1) dones++;
            tick();
        end
        n_cmp++;
        if (dones !== 0) begin
            n_bad++;
            $display("FAIL midrun_reset_quiet: got %0d busy/done cycles want 0", dones);
        end
    endtask

    task automatic test_random(input int n);
        int lat, busy_n, want_lat;
        logic [2:0] res, want_res;
        logic [W-1:0] av, bv;
        bit to;
        for (int i = 0; i < n; i++) begin
            av = W'($urandom);
            case ($urandom_range(0, 3))
                0:       bv = av;
                1:       bv = av ^ W'(32'd1 << $urandom_range(0, W - 1));
                default: bv = W'($urandom);
            endcase
            if (i == 0) begin av = '0; bv = '0; end
            if (i == 1) begin av = '1; bv = '1; end
            if (i == 2) begin av = '1; bv = '0; end
            model(av, bv, want_res, want_lat);
            launch(av, bv);
            wait_done(lat, busy_n, res, to);
            n_cmp++;
            if (to || res !== want_res || lat !== want_lat || busy_n !== want_lat - 1) begin
                n_bad++;
                $display("FAIL random a=%h b=%h: res %b lat %0d busy %0d to %0b want res %b lat %0d busy %0d",
                         av, bv, res, lat, busy_n, to, want_res, want_lat, want_lat - 1);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_directed("equal", 8'hA5, 8'hA5, 5, 3'b010);
        test_directed("msb_exit", 8'hC0, 8'h40, 2, 3'b100);
        test_directed("mid_lt", 8'h1B, 8'h1C, 4, 3'b001);
        test_ignore_hold();
        test_back_to_back_reset();
        test_random(3000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
